// File: rtl/shift_rows_pipe_if.sv
// Block stream: one Rijndael state plus direction and sideband tag.
// The master drives the payload and the slave returns ready.
interface shift_rows_pipe_if #(
  parameter int BW    = 128,
  parameter int TAG_W = 4
);
  logic             valid;
  logic             ready;
  logic             inv;
  logic [TAG_W-1:0] tag;
  logic [BW-1:0]    data;

  modport master (output valid, inv, tag, data, input ready);
  modport slave  (input valid, inv, tag, data, output ready);
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for NB = 4/6/8 with a 2-entry output FIFO.
// The transform is applied at acceptance, so out_* comes straight from FIFO registers.
module shift_rows_lane #(
  parameter int NB    = 4,
  parameter int SHIFT = 0
) (
  input  logic                inv,
  input  logic [NB-1:0][7:0]  row,
  output logic [NB-1:0][7:0]  res
);
  for (genvar c = 0; c < NB; c++) begin : g_col
    assign res[c] = inv ? row[(c - SHIFT + NB) % NB] : row[(c + SHIFT) % NB];
  end
endmodule

module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_rows_pipe_if.slave  in_bus,
  shift_rows_pipe_if.master out_bus,
  output logic            busy
);
  localparam int BW = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [3:0][NB-1:0][7:0] rows, rot;
  logic [BW-1:0]           xf;

  // Byte k = 4c+r sits at [BW-1-8k -: 8]; regroup into rows for the rotators.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int S = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_byte
      assign rows[r][c] = in_bus.data[BW-1-8*(4*c+r) -: 8];
      assign xf[BW-1-8*(4*c+r) -: 8] = rot[r][c];
    end
    shift_rows_lane #(.NB(NB), .SHIFT(S)) u_lane (
      .inv (in_bus.inv),
      .row (rows[r]),
      .res (rot[r])
    );
  end

  logic [1:0][BW-1:0]    mem_data;
  logic [1:0][TAG_W-1:0] mem_tag;
  logic [1:0]            mem_inv;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  push, pop;

  assign in_bus.ready  = (count != 2'd2);
  assign out_bus.valid = (count != 2'd0);
  assign out_bus.data  = mem_data[rd_ptr];
  assign out_bus.tag   = mem_tag[rd_ptr];
  assign out_bus.inv   = mem_inv[rd_ptr];
  assign busy          = out_bus.valid;

  assign push = in_bus.valid & in_bus.ready;
  assign pop  = out_bus.valid & out_bus.ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_data <= '0;
      mem_tag  <= '0;
      mem_inv  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= xf;
        mem_tag[wr_ptr]  <= in_bus.tag;
        mem_inv[wr_ptr]  <= in_bus.inv;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 table vectors, NB=8 round trip,
// back-pressure, streaming throughput and mid-traffic reset.
module tb_shift_rows_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic busy4, busy8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_rows_pipe_if #(.BW(128), .TAG_W(4)) in4 ();
  shift_rows_pipe_if #(.BW(128), .TAG_W(4)) out4 ();
  shift_rows_pipe_if #(.BW(256), .TAG_W(4)) in8 ();
  shift_rows_pipe_if #(.BW(256), .TAG_W(4)) out8 ();

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(in4), .out_bus(out4), .busy(busy4));
  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_bus(in8), .out_bus(out8), .busy(busy8));

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vec [5];

  localparam logic [127:0] RAMP4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FWD4  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [255:0] FWD8  =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model4(input logic [127:0] d, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = d[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  logic [255:0] ramp8;
  logic [127:0] sd [16];

  initial begin
    vec[0] = '{1'b0, RAMP4, FWD4};
    vec[1] = '{1'b1, FWD4, RAMP4};
    vec[2] = '{1'b0, FWD4, 128'h0009020b040d060f08010a030c050e07};
    vec[3] = '{1'b1, RAMP4, 128'h000d0a0704010e0b0805020f0c090603};
    vec[4] = '{1'b0, {4{32'hdeadbeef}}, {4{32'hdeadbeef}}};
    for (int k = 0; k < 32; k++) ramp8[255-8*k -: 8] = k[7:0];

    rst_n = 1'b0;
    in4.valid = 1'b0; in4.inv = 1'b0; in4.tag = '0; in4.data = '0; out4.ready = 1'b1;
    in8.valid = 1'b0; in8.inv = 1'b0; in8.tag = '0; in8.data = '0; out8.ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {255'd0, out4.valid}, 256'd0);
    chk("rst_in_ready",  {255'd0, in4.ready},  256'd1);
    chk("rst_busy",      {255'd0, busy4},      256'd0);
    chk("rst_out_data",  {128'd0, out4.data},  256'd0);
    chk("rst_out_tag",   {252'd0, out4.tag},   256'd0);
    chk("rst_out8_valid",{255'd0, out8.valid}, 256'd0);
    rst_n = 1'b1;

    // table vectors: one block each, 1-cycle latency, then drained
    for (int i = 0; i < 5; i++) begin
      in4.valid = 1'b1; in4.inv = vec[i].inv; in4.data = vec[i].din; in4.tag = i[3:0];
      step();
      in4.valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {255'd0, out4.valid}, 256'd1);
      chk($sformatf("vec%0d_data", i),  {128'd0, out4.data},  {128'd0, vec[i].dout});
      chk($sformatf("vec%0d_tag", i),   {252'd0, out4.tag},   {252'd0, i[3:0]});
      step();
      chk($sformatf("vec%0d_drain", i), {255'd0, out4.valid}, 256'd0);
    end

    // NB=8 forward then inverse round trip
    in8.valid = 1'b1; in8.inv = 1'b0; in8.data = ramp8; in8.tag = 4'd1;
    step();
    in8.valid = 1'b0;
    chk("nb8_col0", {224'd0, out8.data[255:224]}, {224'd0, 32'h00050e13});
    chk("nb8_fwd",  out8.data, FWD8);
    in8.valid = 1'b1; in8.inv = 1'b1; in8.data = FWD8; in8.tag = 4'd2;
    step();
    in8.valid = 1'b0;
    chk("nb8_inv",  out8.data, ramp8);
    chk("nb8_tag",  {252'd0, out8.tag}, {252'd0, 4'd2});

    // back-pressure: tags 1,2 accepted, 3 held until space frees up
    out4.ready = 1'b0;
    in4.valid = 1'b1; in4.inv = 1'b0; in4.data = RAMP4; in4.tag = 4'd1;
    step();
    chk("bp_ready1", {255'd0, in4.ready}, 256'd1);
    chk("bp_head1",  {252'd0, out4.tag},  {252'd0, 4'd1});
    in4.tag = 4'd2;
    step();
    chk("bp_full_ready", {255'd0, in4.ready}, 256'd0);
    chk("bp_busy",       {255'd0, busy4},     256'd1);
    in4.tag = 4'd3;
    step();
    chk("bp_hold_ready", {255'd0, in4.ready}, 256'd0);
    chk("bp_hold_tag",   {252'd0, out4.tag},  {252'd0, 4'd1});
    chk("bp_hold_data",  {128'd0, out4.data}, {128'd0, FWD4});
    out4.ready = 1'b1;
    step();
    chk("bp_out2",    {252'd0, out4.tag},  {252'd0, 4'd2});
    chk("bp_ready_r", {255'd0, in4.ready}, 256'd1);
    step();
    in4.valid = 1'b0;
    chk("bp_out3",    {252'd0, out4.tag},   {252'd0, 4'd3});
    chk("bp_valid3",  {255'd0, out4.valid}, 256'd1);
    step();
    chk("bp_empty",   {255'd0, out4.valid}, 256'd0);

    // 16-block stream with alternating direction at 1 block/cycle
    for (int i = 0; i < 16; i++) sd[i] = {$urandom, $urandom, $urandom, $urandom};
    in4.valid = 1'b1; in4.inv = 1'b0; in4.data = sd[0]; in4.tag = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("st%0d_ready", i), {255'd0, in4.ready},  256'd1);
      chk($sformatf("st%0d_valid", i), {255'd0, out4.valid}, 256'd1);
      chk($sformatf("st%0d_tag", i),   {252'd0, out4.tag},   {252'd0, i[3:0]});
      chk($sformatf("st%0d_data", i),  {128'd0, out4.data},  {128'd0, model4(sd[i], i[0])});
      if (i < 15) begin
        in4.inv = ~i[0]; in4.data = sd[i+1]; in4.tag = 4'(i + 1);
      end else in4.valid = 1'b0;
    end
    step();
    chk("st_empty", {255'd0, out4.valid}, 256'd0);

    // reset while full, with a push and pop pending in the same cycle
    out4.ready = 1'b0;
    in4.valid = 1'b1; in4.inv = 1'b0; in4.data = RAMP4; in4.tag = 4'd5;
    step();
    in4.tag = 4'd6;
    step();
    chk("rf_full", {255'd0, in4.ready}, 256'd0);
    in4.tag = 4'd7; rst_n = 1'b0; out4.ready = 1'b1;
    step();
    rst_n = 1'b1; in4.valid = 1'b0;
    chk("rf_valid", {255'd0, out4.valid}, 256'd0);
    chk("rf_ready", {255'd0, in4.ready},  256'd1);
    chk("rf_data",  {128'd0, out4.data},  256'd0);
    chk("rf_tag",   {252'd0, out4.tag},   256'd0);
    in4.valid = 1'b1; in4.inv = 1'b1; in4.data = RAMP4; in4.tag = 4'd9;
    step();
    in4.valid = 1'b0;
    chk("rf_post_valid", {255'd0, out4.valid}, 256'd1);
    chk("rf_post_tag",   {252'd0, out4.tag},   {252'd0, 4'd9});
    chk("rf_post_data",  {128'd0, out4.data},  {128'd0, 128'h000d0a0704010e0b0805020f0c090603});
    step();
    chk("rf_post_alone", {255'd0, out4.valid}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
